// File: rtl/alu_seq_pkg.sv
// Shared definitions for the nibble-serial add/subtract unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_ADC = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_SBC = 3'b011;
    localparam logic [2:0] OP_INC = 3'b100;
    localparam logic [2:0] OP_DEC = 3'b101;
    localparam logic [2:0] OP_CMP = 3'b110;
    localparam logic [2:0] OP_CLC = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int FLG_C = 0;
    localparam int FLG_Z = 1;
    localparam int FLG_N = 2;
    localparam int FLG_V = 3;
    localparam int FLG_H = 4;

endpackage

// File: rtl/adder4.sv
// 4-bit ripple adder with carry in/out, shared by both nibble phases.
// Latency: combinational.
// Backpressure: none.
module adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    // Plain nibble add; the carry-out is the fifth bit of the widened sum.
    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    end

endmodule

// File: rtl/alu_add_sequencer.sv
// 8-bit add/sub over one shared 4-bit adder: low nibble phase, then high nibble phase.
// Latency: accept edge + 2 edges to result (CLC: accept + 1); one op per 4 cycles sustained.
// Backpressure: result held in DONE until res_ready; requests ignored outside IDLE.
module alu_add_sequencer
    import alu_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] result,
    output logic [4:0] flags
);

    state_t     state_q, state_d;
    logic [2:0] op_q;
    logic [7:0] a_q;
    logic [7:0] bp_q;
    logic       cin_q;
    logic [3:0] lo_sum_q;
    logic       nib_c_q;
    logic [7:0] result_q;
    logic [4:0] flags_q;

    logic [7:0] bp_sel;
    logic       cin_sel;
    logic [3:0] add_a, add_b, add_sum;
    logic       add_cin, add_cout;
    logic [7:0] full_sum;
    logic [4:0] arith_flags;
    logic [4:0] clc_flags;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state: CLC skips the high phase and completes out of LO.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid) state_d = ST_LO;
            ST_LO:   state_d = (op_q == OP_CLC) ? ST_DONE : ST_HI;
            ST_HI:   state_d = ST_DONE;
            ST_DONE: if (res_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Effective B operand and carry-in, chosen at acceptance using the committed C flag.
    always_comb begin
        bp_sel  = b;
        cin_sel = 1'b0;
        case (op)
            OP_ADD: begin bp_sel = b;     cin_sel = 1'b0;           end
            OP_ADC: begin bp_sel = b;     cin_sel = flags_q[FLG_C]; end
            OP_SUB: begin bp_sel = ~b;    cin_sel = 1'b1;           end
            OP_SBC: begin bp_sel = ~b;    cin_sel = flags_q[FLG_C]; end
            OP_INC: begin bp_sel = 8'h00; cin_sel = 1'b1;           end
            OP_DEC: begin bp_sel = 8'hFF; cin_sel = 1'b0;           end
            OP_CMP: begin bp_sel = ~b;    cin_sel = 1'b1;           end
            default: begin bp_sel = b;    cin_sel = 1'b0;           end
        endcase
    end

    // Adder input mux: high nibble plus registered nibble carry in HI, low nibble otherwise.
    always_comb begin
        add_a   = a_q[3:0];
        add_b   = bp_q[3:0];
        add_cin = cin_q;
        if (state_q == ST_HI) begin
            add_a   = a_q[7:4];
            add_b   = bp_q[7:4];
            add_cin = nib_c_q;
        end
    end

    adder4 u_adder4 (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Flags for the arithmetic completion (HI phase) and for CLC.
    always_comb begin
        full_sum               = {add_sum, lo_sum_q};
        arith_flags            = 5'b00000;
        arith_flags[FLG_C]     = add_cout;
        arith_flags[FLG_H]     = nib_c_q;
        arith_flags[FLG_Z]     = (full_sum == 8'h00);
        arith_flags[FLG_N]     = full_sum[7];
        arith_flags[FLG_V]     = (a_q[7] == bp_q[7]) && (full_sum[7] != a_q[7]);
        clc_flags              = 5'b00000;
        clc_flags[FLG_Z]       = (a_q == 8'h00);
        clc_flags[FLG_N]       = a_q[7];
    end

    // Datapath registers: operand capture, low-nibble result, architectural result/flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= OP_ADD;
            a_q      <= 8'h00;
            bp_q     <= 8'h00;
            cin_q    <= 1'b0;
            lo_sum_q <= 4'h0;
            nib_c_q  <= 1'b0;
            result_q <= 8'h00;
            flags_q  <= 5'b00000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q  <= op;
                        a_q   <= a;
                        bp_q  <= bp_sel;
                        cin_q <= cin_sel;
                    end
                end
                ST_LO: begin
                    if (op_q == OP_CLC) begin
                        result_q <= a_q;
                        flags_q  <= clc_flags;
                    end else begin
                        lo_sum_q <= add_sum;
                        nib_c_q  <= add_cout;
                    end
                end
                ST_HI: begin
                    result_q <= (op_q == OP_CMP) ? a_q : full_sum;
                    flags_q  <= arith_flags;
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign res_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_add_sequencer.sv
// Directed bench for the nibble-serial add/subtract unit.
// Latency: n/a.
// Backpressure: exercised by holding res_ready low after a completion.
module tb_alu_add_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] result;
    logic [4:0] flags;

    int checks = 0;
    int errors = 0;

    alu_add_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Issue one op, scramble the inputs after acceptance, wait for completion and check it.
    // Leaves the unit in DONE; the caller decides when to release.
    task automatic run(input string tag, input logic [2:0] o, input logic [7:0] va,
                       input logic [7:0] vb, input int exp_lat,
                       input logic [7:0] exp_res, input logic [4:0] exp_flg);
        int edges;
        op = o; a = va; b = vb; req_valid = 1'b1;
        tick();
        edges = 1;
        req_valid = 1'b0;
        op = ~o; a = ~va; b = ~vb;
        while (!res_valid && edges < 10) begin
            tick();
            edges++;
        end
        chk({tag, "_lat"}, 8'(edges), 8'(exp_lat));
        chk({tag, "_res"}, result, exp_res);
        chk({tag, "_flg"}, {3'b000, flags}, {3'b000, exp_flg});
    endtask

    task automatic release_done(input string tag);
        res_ready = 1'b1;
        tick();
        chk({tag, "_rel_vld"}, {7'd0, res_valid}, 8'd0);
        chk({tag, "_rel_rdy"}, {7'd0, req_ready}, 8'd1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; op = 3'b000; a = 8'h00; b = 8'h00; res_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_req_ready", {7'd0, req_ready}, 8'd1);
        chk("rst_res_valid", {7'd0, res_valid}, 8'd0);
        chk("rst_result", result, 8'h00);
        chk("rst_flags", {3'b000, flags}, 8'h00);

        // flags order {H,V,N,Z,C}
        run("add_3a_29", 3'b000, 8'h3A, 8'h29, 3, 8'h63, 5'b10000);
        release_done("add_3a_29");
        run("add_ff_01", 3'b000, 8'hFF, 8'h01, 3, 8'h00, 5'b10011);
        release_done("add_ff_01");
        run("adc_00_00", 3'b001, 8'h00, 8'h00, 3, 8'h01, 5'b00000);
        release_done("adc_00_00");
        run("sub_50_70", 3'b010, 8'h50, 8'h70, 3, 8'hE0, 5'b10100);
        release_done("sub_50_70");

        // CMP completes, then the consumer stalls while the requester churns the inputs.
        res_ready = 1'b0;
        run("cmp_80_01", 3'b110, 8'h80, 8'h01, 3, 8'h80, 5'b01001);
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            op = 3'(i); a = 8'(i * 37 + 5); b = 8'(i * 91 + 3);
            tick();
            chk("stall_result", result, 8'h80);
            chk("stall_flags", {3'b000, flags}, {3'b000, 5'b01001});
            chk("stall_req_ready", {7'd0, req_ready}, 8'd0);
            chk("stall_res_valid", {7'd0, res_valid}, 8'd1);
        end
        op = 3'b000; a = 8'h01; b = 8'h02;
        release_done("cmp_80_01");
        run("add_after_stall", 3'b000, 8'h01, 8'h02, 3, 8'h03, 5'b00000);
        release_done("add_after_stall");

        // Make C=1, then reset in the LO phase of an INC; ADC afterwards must see C=0.
        run("add_ff_01_b", 3'b000, 8'hFF, 8'h01, 3, 8'h00, 5'b10011);
        release_done("add_ff_01_b");
        op = 3'b100; a = 8'h7F; b = 8'h00; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("inc_in_lo", {7'd0, req_ready}, 8'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_req_ready", {7'd0, req_ready}, 8'd1);
        chk("midrst_res_valid", {7'd0, res_valid}, 8'd0);
        chk("midrst_result", result, 8'h00);
        chk("midrst_flags", {3'b000, flags}, 8'h00);
        run("adc_01_01", 3'b001, 8'h01, 8'h01, 3, 8'h02, 5'b00000);
        release_done("adc_01_01");

        // CLC after C=1, then DEC of zero.
        run("add_ff_01_c", 3'b000, 8'hFF, 8'h01, 3, 8'h00, 5'b10011);
        release_done("add_ff_01_c");
        run("clc_85", 3'b111, 8'h85, 8'h33, 2, 8'h85, 5'b00100);
        release_done("clc_85");
        run("dec_00", 3'b101, 8'h00, 8'h00, 3, 8'hFF, 5'b00100);
        release_done("dec_00");

        // SBC with C=0 from DEC: 0x10 - 0x01 - 1 = 0x0E, low nibble borrows.
        run("sbc_10_01", 3'b011, 8'h10, 8'h01, 3, 8'h0E, 5'b00001);
        release_done("sbc_10_01");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
